// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the register file with context save/restore.
// Decode and control import the same defaults so port widths stay consistent.
package reg_file_pkg;

  // Copy-engine state: idle, copying registers into the shadow bank, or back again
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2
  } ctx_state_t;

  // Default data width, address width and status width
  localparam int DEF_W  = 16;
  localparam int DEF_A  = 4;
  localparam int DEF_SW = 2;

  // Number of registers for a given address width
  function automatic int depth_of(input int a);
    return 1 << a;
  endfunction

endpackage

// File: rtl/reg_file_ctx_seq.sv
// Sequencer for the context copy engine: accepts save/restore requests while
// idle, walks a counter over every register index, and flags the final copy.
module reg_file_ctx_seq
  import reg_file_pkg::*;
#(
  parameter int A = DEF_A
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         SaveReq,
  input  logic         RestoreReq,
  output ctx_state_t   state,
  output logic [A-1:0] cnt,
  output logic         last,
  output logic         Busy,
  output logic         Done
);

  ctx_state_t   state_reg;
  logic [A-1:0] cnt_reg;
  logic         busy_reg;
  logic         done_reg;

  // The final copy happens when the counter sits on the highest index
  assign last = (state_reg != IDLE) && (cnt_reg == {A{1'b1}});

  // Request acceptance, index walk and registered Busy/Done generation
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          // Save takes priority when both requests arrive together
          if (SaveReq) begin
            state_reg <= SAVE;
            busy_reg  <= 1'b1;
          end else if (RestoreReq) begin
            state_reg <= RESTORE;
            busy_reg  <= 1'b1;
          end
        end
        SAVE, RESTORE: begin
          // Counter wraps to zero naturally after the last index
          cnt_reg <= cnt_reg + A'(1);
          if (last) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign state = state_reg;
  assign cnt   = cnt_reg;
  assign Busy  = busy_reg;
  assign Done  = done_reg;

endmodule

// File: rtl/reg_file_ctx.sv
// Register file with two combinational read ports, one write port, a status
// register and a shadow bank. The shadow bank is filled or drained one entry
// per cycle by the sequencer; normal writes are dropped while it runs.
module reg_file_ctx
  import reg_file_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int A      = DEF_A,
  parameter int SW     = DEF_SW,
  parameter int BYPASS = 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          WriteEn,
  input  logic          StFlag,
  input  logic [A-1:0]  RaddrA,
  input  logic [A-1:0]  RaddrB,
  input  logic [A-1:0]  Waddr,
  input  logic [W-1:0]  DataIn,
  input  logic          SaveReq,
  input  logic          RestoreReq,
  output logic [W-1:0]  DataOutA,
  output logic [W-1:0]  DataOutB,
  output logic [SW-1:0] S,
  output logic          Busy,
  output logic          Done
);

  localparam int DEPTH = depth_of(A);
  localparam bit BYPASS_EN = (BYPASS != 0);

  logic [W-1:0]  regs_reg   [DEPTH];
  logic [W-1:0]  shadow_reg [DEPTH];
  logic [SW-1:0] s_reg;
  logic [SW-1:0] shadow_s_reg;

  ctx_state_t    ctx_state;
  logic [A-1:0]  ctx_cnt;
  logic          ctx_last;
  logic          ctx_busy;
  logic          ctx_done;

  logic          wr_ok;
  logic          st_ok;

  reg_file_ctx_seq #(
    .A (A)
  ) u_seq (
    .Clk        (Clk),
    .Reset      (Reset),
    .SaveReq    (SaveReq),
    .RestoreReq (RestoreReq),
    .state      (ctx_state),
    .cnt        (ctx_cnt),
    .last       (ctx_last),
    .Busy       (ctx_busy),
    .Done       (ctx_done)
  );

  // Caller must stall on Busy; anything issued during a copy is discarded
  assign wr_ok = WriteEn && !ctx_busy;
  assign st_ok = StFlag  && !ctx_busy;

  // Main array: cleared on reset, refilled from shadow during restore, else normal writes
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (ctx_state == RESTORE) begin
      regs_reg[ctx_cnt] <= shadow_reg[ctx_cnt];
    end else if (wr_ok) begin
      regs_reg[Waddr] <= DataIn;
    end
  end

  // Shadow bank: cleared on reset, captures one register per cycle during save
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        shadow_reg[i] <= '0;
      end
    end else if (ctx_state == SAVE) begin
      shadow_reg[ctx_cnt] <= regs_reg[ctx_cnt];
    end
  end

  // Status register: restored alongside the final register copy, else loaded by StFlag
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s_reg <= '0;
    end else if ((ctx_state == RESTORE) && ctx_last) begin
      s_reg <= shadow_s_reg;
    end else if (st_ok) begin
      s_reg <= DataIn[SW-1:0];
    end
  end

  // Shadow status: captured alongside the final register copy of a save
  always_ff @(posedge Clk) begin
    if (Reset) begin
      shadow_s_reg <= '0;
    end else if ((ctx_state == SAVE) && ctx_last) begin
      shadow_s_reg <= s_reg;
    end
  end

  // Read ports share identical logic, so build both from one template
  logic [A-1:0] raddr [2];
  logic [W-1:0] rdata [2];

  assign raddr[0] = RaddrA;
  assign raddr[1] = RaddrB;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      // Array read with optional same-cycle forwarding of an accepted write
      always_comb begin
        rdata[gi] = regs_reg[raddr[gi]];
        if (BYPASS_EN && wr_ok && (Waddr == raddr[gi])) begin
          rdata[gi] = DataIn;
        end
      end
    end
  endgenerate

  assign DataOutA = rdata[0];
  assign DataOutB = rdata[1];
  assign S        = s_reg;
  assign Busy     = ctx_busy;
  assign Done     = ctx_done;

endmodule

// File: tb/tb_reg_file_ctx.sv
// Scoreboard bench for reg_file_ctx: stimulus pushes expected values tagged
// with the cycle they apply to; a negedge monitor compares and also matches
// every Done pulse against the expected completion cycle.
module tb_reg_file_ctx;
  import reg_file_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset, WriteEn, StFlag, SaveReq, RestoreReq;
  logic [3:0]  RaddrA, RaddrB, Waddr;
  logic [15:0] DataIn;
  logic [15:0] a1, b1, a0, b0;
  logic [1:0]  s1, s0;
  logic        busy1, busy0, done1, done0;

  always #5 Clk = ~Clk;

  reg_file_ctx #(.W(16), .A(4), .SW(2), .BYPASS(1)) dut_byp (
    .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .StFlag(StFlag),
    .RaddrA(RaddrA), .RaddrB(RaddrB), .Waddr(Waddr), .DataIn(DataIn),
    .SaveReq(SaveReq), .RestoreReq(RestoreReq),
    .DataOutA(a1), .DataOutB(b1), .S(s1), .Busy(busy1), .Done(done1)
  );

  reg_file_ctx #(.W(16), .A(4), .SW(2), .BYPASS(0)) dut_nob (
    .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .StFlag(StFlag),
    .RaddrA(RaddrA), .RaddrB(RaddrB), .Waddr(Waddr), .DataIn(DataIn),
    .SaveReq(SaveReq), .RestoreReq(RestoreReq),
    .DataOutA(a0), .DataOutB(b0), .S(s0), .Busy(busy0), .Done(done0)
  );

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    int          sel;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t exq[$];
  int   doneq[$];
  int   checks = 0;
  int   failures = 0;
  logic [15:0] mon_act;
  int   mon_exp_cyc;

  function automatic logic [15:0] pick(input int sel);
    case (sel)
      0: return a1;
      1: return b1;
      2: return {14'b0, s1};
      3: return {15'b0, busy1};
      4: return a0;
      5: return {15'b0, done1};
      6: return b0;
      default: return 16'hxxxx;
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle, and account for each Done pulse
  always @(negedge Clk) begin
    for (int i = exq.size() - 1; i >= 0; i--) begin
      if (exq[i].due == cyc) begin
        mon_act = pick(exq[i].sel);
        checks++;
        if (mon_act !== exq[i].exp) begin
          failures++;
          $display("FAIL %s cyc=%0d actual=%h required=%h", exq[i].name, cyc, mon_act, exq[i].exp);
        end else begin
          $display("ok   %s cyc=%0d value=%h", exq[i].name, cyc, mon_act);
        end
        exq.delete(i);
      end
    end
    if (done1 === 1'b1) begin
      checks++;
      if (doneq.size() == 0) begin
        failures++;
        $display("FAIL done_unexpected cyc=%0d actual=1 required=0", cyc);
      end else begin
        mon_exp_cyc = doneq.pop_front();
        if (mon_exp_cyc != cyc) begin
          failures++;
          $display("FAIL done_cycle actual=%0d required=%0d", cyc, mon_exp_cyc);
        end else begin
          $display("ok   done_cycle cyc=%0d", cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic expect_v(input int due, input int sel, input logic [15:0] v, input string name);
    exp_t e;
    e.due = due;
    e.sel = sel;
    e.exp = v;
    e.name = name;
    exq.push_back(e);
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] b,
                    input logic [15:0] ea, input logic [15:0] eb, input string name);
    RaddrA = a;
    RaddrB = b;
    expect_v(cyc, 0, ea, {name, "_A"});
    expect_v(cyc, 1, eb, {name, "_B"});
    tick();
  endtask

  task automatic wr(input logic [3:0] addr, input logic [15:0] data);
    WriteEn = 1'b1;
    Waddr = addr;
    DataIn = data;
    tick();
    WriteEn = 1'b0;
  endtask

  task automatic stf(input logic [15:0] data);
    StFlag = 1'b1;
    DataIn = data;
    tick();
    StFlag = 1'b0;
  endtask

  // Issue a request for one cycle; full=1 also schedules busy/done timing expectations
  task automatic start(input logic sv, input logic rs, input bit full, input string name);
    SaveReq = sv;
    RestoreReq = rs;
    expect_v(cyc + 1, 3, 16'h1, {name, "_busy_first"});
    if (full) begin
      expect_v(cyc + 16, 3, 16'h1, {name, "_busy_last"});
      expect_v(cyc + 17, 3, 16'h0, {name, "_busy_clear"});
      doneq.push_back(cyc + 17);
    end
    tick();
    SaveReq = 1'b0;
    RestoreReq = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done1 !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_done required=done", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; WriteEn = 1'b0; StFlag = 1'b0; SaveReq = 1'b0; RestoreReq = 1'b0;
    RaddrA = '0; RaddrB = '0; Waddr = '0; DataIn = '0;
    tick(); tick();
    Reset = 1'b0;

    // 1: reset state, basic write/read, reset clears
    expect_v(cyc, 3, 16'h0, "rst_busy");
    expect_v(cyc, 5, 16'h0, "rst_done");
    expect_v(cyc, 2, 16'h0, "rst_s");
    rd(4'd3, 4'd7, 16'h0, 16'h0, "rst_regs");
    wr(4'd3, 16'hBEEF);
    wr(4'd7, 16'h1234);
    rd(4'd3, 4'd7, 16'hBEEF, 16'h1234, "t1_read");
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    rd(4'd3, 4'd7, 16'h0, 16'h0, "t1_after_rst");

    // 2: same-cycle bypass versus array-only read
    WriteEn = 1'b1; Waddr = 4'd5; DataIn = 16'hA5A5; RaddrA = 4'd5;
    expect_v(cyc, 0, 16'hA5A5, "t2_bypass_on");
    expect_v(cyc, 4, 16'h0000, "t2_bypass_off");
    tick();
    WriteEn = 1'b0;
    expect_v(cyc, 4, 16'hA5A5, "t2_nob_next");
    tick();

    // 3: save, clobber, restore
    for (int i = 0; i < 16; i++) wr(4'(i), 16'(i) * 16'h0101);
    stf(16'h0002);
    expect_v(cyc, 2, 16'h2, "t3_s_set");
    start(1'b1, 1'b0, 1'b1, "t3_save");
    wait_done("t3_save");
    for (int i = 0; i < 16; i++) wr(4'(i), 16'h0);
    stf(16'h0000);
    expect_v(cyc, 2, 16'h0, "t3_s_clr");
    rd(4'd5, 4'd9, 16'h0, 16'h0, "t3_clobbered");
    start(1'b0, 1'b1, 1'b1, "t3_restore");
    wait_done("t3_restore");
    expect_v(cyc, 2, 16'h2, "t3_s_restored");
    for (int i = 0; i < 8; i++)
      rd(4'(2 * i), 4'(2 * i + 1), 16'(2 * i) * 16'h0101, 16'(2 * i + 1) * 16'h0101,
         $sformatf("t3_r%0d", 2 * i));

    // 4: write and restore request during save are both dropped
    start(1'b1, 1'b0, 1'b1, "t4_save");
    tick();
    WriteEn = 1'b1; Waddr = 4'd2; DataIn = 16'hFFFF; RestoreReq = 1'b1;
    tick();
    WriteEn = 1'b0; RestoreReq = 1'b0;
    wait_done("t4_save");
    rd(4'd2, 4'd3, 16'h0202, 16'h0303, "t4_r2_kept");
    expect_v(cyc, 3, 16'h0, "t4_no_queued_restore");
    tick();

    // 5: simultaneous requests run a save
    wr(4'd0, 16'h1111);
    start(1'b1, 1'b1, 1'b1, "t5_both");
    wait_done("t5_both");
    rd(4'd0, 4'd1, 16'h1111, 16'h0101, "t5_regs_kept");
    wr(4'd0, 16'h0000);
    start(1'b0, 1'b1, 1'b1, "t5_restore");
    wait_done("t5_restore");
    rd(4'd0, 4'd1, 16'h1111, 16'h0101, "t5_shadow_had_save");

    // 6: reset during restore aborts and clears everything
    start(1'b0, 1'b1, 1'b0, "t6_restore");
    tick(); tick(); tick(); tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    expect_v(cyc, 3, 16'h0, "t6_busy");
    expect_v(cyc, 5, 16'h0, "t6_done");
    expect_v(cyc, 2, 16'h0, "t6_s");
    rd(4'd0, 4'd1, 16'h0, 16'h0, "t6_regs_lo");
    rd(4'd2, 4'd15, 16'h0, 16'h0, "t6_regs_hi");
    wr(4'd1, 16'hBEEF);
    stf(16'h0003);
    start(1'b0, 1'b1, 1'b1, "t6_restore2");
    wait_done("t6_restore2");
    expect_v(cyc, 2, 16'h0, "t6_shadow_s");
    rd(4'd1, 4'd2, 16'h0, 16'h0, "t6_shadow_regs");

    tick(); tick(); tick();
    checks++;
    if (exq.size() != 0) begin
      failures++;
      $display("FAIL pending_expects actual=%0d required=0", exq.size());
    end
    checks++;
    if (doneq.size() != 0) begin
      failures++;
      $display("FAIL missing_done actual=%0d required=0", doneq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
